// File: rtl/shift_add_mul.sv
// Iterative radix-2 unsigned multiplier: resolves one product bit per clock using
// a start/busy/ready handshake shared with the Goldschmidt divider.
module shift_add_mul #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             start,
    output logic [2*N-1:0]   p,
    output logic             busy,
    output logic             ready,
    output logic [CW-1:0]    count,
    output logic             ovf
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   p_q, p_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;

    logic [N:0]       sum;
    logic [2*N-1:0]   acc_shift;
    logic             last_iter;

    // Carry lands in sum[N] so it is shifted into the accumulator MSB, never dropped.
    always_comb begin
        sum       = {1'b0, acc_q[2*N-1:N]} + {1'b0, {N{acc_q[0]}} & mcand_q};
        acc_shift = {sum, acc_q[N-1:1]};
        last_iter = (count_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        p_d     = p_q;
        count_d = count_q;
        ready_d = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{N{1'b0}}, b};
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d   = acc_shift;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    p_d     = acc_shift;
                    ovf_d   = |acc_shift[2*N-1:N];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            mcand_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            count_q <= count_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    assign p     = p_q;
    assign busy  = (state_q == StRun);
    assign ready = ready_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul: vector table plus hand-written sequences,
// with a scoreboard queue popped on every ready pulse.
module tb_shift_add_mul;

    localparam int unsigned N  = 32;
    localparam int unsigned CW = 6;

    logic            clk;
    logic            clrn;
    logic [N-1:0]    a, b;
    logic            start;
    logic [2*N-1:0]  p;
    logic            busy, ready, ovf;
    logic [CW-1:0]   count;

    shift_add_mul #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .a     (a),
        .b     (b),
        .start (start),
        .p     (p),
        .busy  (busy),
        .ready (ready),
        .count (count),
        .ovf   (ovf)
    );

    typedef struct {
        logic [2*N-1:0] p;
        logic           ovf;
    } exp_t;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        logic           ovf;
    } vec_t;

    exp_t            sb[$];
    logic [2*N-1:0]  last_p;
    int              n_tests;
    int              n_fail;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clrn && ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("p", p, e.p);
                check("ovf", 64'(ovf), 64'(e.ovf));
                last_p = e.p;
            end
        end
    end

    task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic [2*N-1:0] ep, input logic eo);
        int k;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        sb.push_back('{p: ep, ovf: eo});
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("count_after_accept", 64'(count), 64'd0);
        k = 0;
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
            if (k == N / 2) check("p_held_during_run", p, last_p);
        end
        check("latency", 64'(k), 64'(N));
        check("count_final", 64'(count), 64'(N));
        check("busy_at_ready", 64'(busy), 64'd0);
        @(negedge clk);
        check("ready_one_cycle", 64'(ready), 64'd0);
        check("count_hold_idle", 64'(count), 64'(N));
    endtask

    initial begin
        vec_t vecs[$];
        int   k;
        int   bad;
        logic [N-1:0]   ra, rb;
        logic [2*N-1:0] rp;

        n_tests = 0;
        n_fail  = 0;
        last_p  = '0;
        clrn    = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;

        vecs.push_back('{a: 32'd8,          b: 32'd10,         p: 64'd80,                  ovf: 1'b0});
        vecs.push_back('{a: 32'd221,        b: 32'd5,          p: 64'd1105,                ovf: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001, ovf: 1'b1});
        vecs.push_back('{a: 32'd0,          b: 32'h1234_5678,  p: 64'd0,                   ovf: 1'b0});
        vecs.push_back('{a: 32'h8000_0000,  b: 32'd2,          p: 64'h1_0000_0000,         ovf: 1'b1});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'd1,          p: 64'hFFFF_FFFF,           ovf: 1'b0});
        vecs.push_back('{a: 32'h1234_5678,  b: 32'h0,          p: 64'd0,                   ovf: 1'b0});

        // Reset values
        #12;
        check("rst_p", p, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        #13 clrn = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].ovf);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = 64'(ra) * 64'(rb);
            do_op(ra, rb, rp, |rp[2*N-1:N]);
        end

        // Continuous start: second operands applied while busy, accepted at EN+1.
        @(negedge clk);
        a = 32'd3;
        b = 32'd7;
        start = 1'b1;
        sb.push_back('{p: 64'd21, ovf: 1'b0});
        @(negedge clk);
        a = 32'd6;
        b = 32'd9;
        sb.push_back('{p: 64'd54, ovf: 1'b0});
        k = 0;
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("bb_first_latency", 64'(k), 64'(N));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 200);
        check("bb_ready_interval", 64'(k), 64'(N + 1));
        start = 1'b0;
        @(negedge clk);
        check("bb_idle_after", 64'(busy), 64'd0);
        check("bb_sb_drained", 64'(sb.size()), 64'd0);

        // Async reset mid-operation
        @(negedge clk);
        a = 32'd1000;
        b = 32'd1000;
        start = 1'b1;
        sb.push_back('{p: 64'd1000000, ovf: 1'b0});
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (count != CW'(15) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_count15", 64'(count), 64'd15);
        #2 clrn = 1'b0;
        #1;
        check("arst_p", p, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ready", 64'(ready), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        sb.delete();
        last_p = '0;
        @(negedge clk);
        clrn = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready || busy) bad++;
        end
        check("no_ready_after_arst", 64'(bad), 64'd0);

        // Result must hold indefinitely while idle
        do_op(32'd2, 32'd3, 64'd6, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (p !== 64'd6 || ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_hold", 64'(bad), 64'd0);
        check("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
